// File: rtl/shift_add_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier_if
// Description : Handshake and data bundle between a requester and the
//               sequential shift-and-add multiplier.
// Revision    : 1.0  initial release
// ============================================================================
interface shift_add_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic                   res_clr;
    logic                   res_ld;

    // Requester side: issues operands, observes status and result.
    modport master (
        output start, a, b,
        input  busy, done, product, res_clr, res_ld
    );

    // Multiplier side.
    modport slave (
        input  start, a, b,
        output busy, done, product, res_clr, res_ld
    );
endinterface
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier
// Description : Unsigned sequential shift-and-add multiplier. One CLEAR cycle,
//               WIDTH CALC cycles, one DONE cycle; drives the clear/load
//               strobes of the downstream result register.
// Revision    : 1.0  initial release
// ============================================================================
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    shift_add_multiplier_if.slave   mul_if
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_CALC  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Counter value held during the final CALC cycle.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [PW-1:0]    mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q,    acc_d;

    logic             busy;
    logic             done;
    logic             res_clr;
    logic             res_ld;

    // State register; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mul_if.start) state_d = S_CLEAR;
            S_CLEAR: state_d = S_CALC;
            S_CALC:  if (cnt_q == LAST_CNT) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: capture on accept, then one add/shift per CALC cycle.
    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            S_IDLE: begin
                if (mul_if.start) begin
                    mcand_d  = {{WIDTH{1'b0}}, mul_if.a};
                    mplier_d = mul_if.b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = '0;
            end
            S_CALC: begin
                // Product of two WIDTH-bit values always fits in PW bits.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
            end
            S_DONE: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath registers; the accumulator doubles as the product output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    // Status strobes decoded from the state register only (no input path).
    always_comb begin
        busy    = (state_q != S_IDLE);
        res_clr = (state_q == S_CLEAR);
        done    = (state_q == S_DONE);
        res_ld  = (state_q == S_DONE);
    end

    assign mul_if.busy    = busy;
    assign mul_if.done    = done;
    assign mul_if.res_clr = res_clr;
    assign mul_if.res_ld  = res_ld;
    assign mul_if.product = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_multiplier
// Description : Self-checking bench for shift_add_multiplier (WIDTH=8) with
//               a model of the downstream 16-bit result register.
// Revision    : 1.0  initial release
// ============================================================================
module tb_shift_add_multiplier;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 2;   // cycle index of done
    localparam int PER   = WIDTH + 3;   // issue period with start held

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [15:0] dreg_q;

    shift_add_multiplier_if #(.WIDTH(WIDTH)) mul_if ();

    shift_add_multiplier #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .mul_if (mul_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream result register: clear on c_clr, load on c_ld.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               dreg_q <= '0;
        else if (mul_if.res_clr) dreg_q <= '0;
        else if (mul_if.res_ld)  dreg_q <= mul_if.product;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},    32'(mul_if.busy),    32'd0);
        check({tag, "_done"},    32'(mul_if.done),    32'd0);
        check({tag, "_res_clr"}, 32'(mul_if.res_clr), 32'd0);
        check({tag, "_res_ld"},  32'(mul_if.res_ld),  32'd0);
        check({tag, "_product"}, 32'(mul_if.product), 32'd0);
    endtask

    // One complete operation from an IDLE negedge; optional ignored start
    // pulses with fresh operands in cycles 4 and LAT (DONE).
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input bit glitch);
        logic [31:0] exp_p;
        exp_p = 32'(xa) * 32'(xb);
        mul_if.start = 1'b1;
        mul_if.a     = xa;
        mul_if.b     = xb;
        for (int cyc = 1; cyc <= PER; cyc++) begin
            tick();
            mul_if.start = 1'b0;
            mul_if.a     = 8'($urandom);
            mul_if.b     = 8'($urandom);
            if (glitch && (cyc == 4 || cyc == LAT)) mul_if.start = 1'b1;
            check("busy",    32'(mul_if.busy),    32'(cyc <= LAT));
            check("res_clr", 32'(mul_if.res_clr), 32'(cyc == 1));
            check("done",    32'(mul_if.done),    32'(cyc == LAT));
            check("res_ld",  32'(mul_if.res_ld),  32'(cyc == LAT));
            if (cyc == 2)   check("dreg_cleared", 32'(dreg_q), 32'd0);
            if (cyc >= LAT) check("product", 32'(mul_if.product), exp_p);
            if (cyc == PER) check("dreg_loaded", 32'(dreg_q), exp_p);
        end
        mul_if.start = 1'b0;
        // Result and downstream register hold while idle.
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_product", 32'(mul_if.product), exp_p);
            check("hold_dreg",    32'(dreg_q),         exp_p);
            check("hold_busy",    32'(mul_if.busy),    32'd0);
        end
    endtask

    // Watchdog: the stimulus is fixed-length, but never allow a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  qa [$];
        logic [7:0]  qb [$];
        logic [31:0] exp_p;
        logic [7:0]  ra, rb;
        int          n_done;

        n_tests      = 0;
        n_fail       = 0;
        mul_if.start = 1'b0;
        mul_if.a     = '0;
        mul_if.b     = '0;
        reset        = 1'b1;
        #2;
        check_idle_zero("reset_init");
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        check_idle_zero("after_reset");

        // Basic and corner operands.
        run_op(8'h0D, 8'h0B, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0);
        run_op(8'h00, 8'hFF, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);

        // Ignored start pulses during an active operation.
        run_op(8'h0D, 8'h0B, 1'b1);

        // Randomised operands, some with ignored start pulses.
        for (int i = 0; i < 8; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'(i % 2));
        end

        // Start held high: an accept every PER cycles, operands randomised
        // every cycle; only the values present at each accept matter.
        n_done = 0;
        mul_if.start = 1'b1;
        for (int t = 0; t < 3 * PER; t++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            mul_if.a = ra;
            mul_if.b = rb;
            if (t % PER == 0) begin
                qa.push_back(ra);
                qb.push_back(rb);
            end
            tick();
            // Now in cycle t+1 of the stream.
            check("cont_done", 32'(mul_if.done), 32'(((t + 1) % PER) == LAT));
            if (((t + 1) % PER) == LAT) begin
                exp_p = 32'(qa.pop_front()) * 32'(qb.pop_front());
                check("cont_product", 32'(mul_if.product), exp_p);
                n_done++;
            end
        end
        mul_if.start = 1'b0;
        check("cont_done_count", 32'(n_done), 32'd3);
        repeat (PER) tick();

        // Asynchronous reset in cycle 5 of an operation.
        mul_if.start = 1'b1;
        mul_if.a     = 8'hAB;
        mul_if.b     = 8'hCD;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            tick();
            mul_if.start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        check_idle_zero("reset_mid_calc");
        tick();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("abort_res_ld",  32'(mul_if.res_ld),  32'd0);
            check("abort_product", 32'(mul_if.product), 32'd0);
            check("abort_busy",    32'(mul_if.busy),    32'd0);
            check("abort_dreg",    32'(dreg_q),         32'd0);
        end
        run_op(8'd3, 8'd7, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
